// File: rtl/uart_tx_drain.sv
// uart_tx_drain: UART transmitter that drains a source FIFO frame by frame.
//
// Each frame is one start bit (low), DBIT data bits LSB first, and a stop
// period of SB_TICK oversample ticks (high). One oversample tick is DVSR
// clock cycles; one data/start bit is 16 ticks.
//
// Ports:
//   clk          system clock, all state updated on the rising edge
//   reset        asynchronous active-low reset (0 = in reset)
//   tx_en        permits launching a new frame while high
//   fifo_empty   source FIFO empty flag
//   fifo_r_data  source FIFO head word, valid whenever fifo_empty = 0
//   fifo_rd      one-cycle pop strobe to the source FIFO
//   tx           serial line, idle high, registered
//   tx_busy      high whenever a frame is in progress (state != IDLE)
//   tx_done_tick one-cycle pulse as the block returns to IDLE after a frame
//   dbg_state    current FSM state (0 IDLE, 1 START, 2 DATA, 3 STOP)
//
// FIFO handshake: the head word is consumed in a cycle where fifo_rd = 1.
// fifo_rd is only raised in IDLE, with tx_en = 1, fifo_empty = 0 and reset
// released; in that same cycle fifo_r_data is captured into the shift
// register, so the FIFO may change freely from the next cycle onwards.
module uart_tx_drain #(
  parameter int DBIT    = 8,
  parameter int SB_TICK = 16,
  parameter int DVSR    = 163
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            tx_en,
  input  logic            fifo_empty,
  input  logic [DBIT-1:0] fifo_r_data,
  output logic            fifo_rd,
  output logic            tx,
  output logic            tx_busy,
  output logic            tx_done_tick,
  output logic [1:0]      dbg_state
);

  // Counter widths: the divider holds DVSR-1, the tick counter holds
  // max(15, SB_TICK-1), the bit counter holds DBIT-1.
  localparam int DW   = (DVSR > 1) ? $clog2(DVSR) : 1;
  localparam int TMAX = (SB_TICK > 16) ? SB_TICK : 16;
  localparam int TW   = $clog2(TMAX);
  localparam int BW   = (DBIT > 1) ? $clog2(DBIT) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [DW-1:0]   div_q, div_d;
  logic [TW-1:0]   tick_q, tick_d;
  logic [BW-1:0]   bit_q, bit_d;
  logic [DBIT-1:0] shift_q, shift_d;
  logic            tx_q, tx_d;
  logic            done_q, done_d;

  logic            launch;
  logic            s_tick;

  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    tick_d  = tick_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    tx_d    = tx_q;
    done_d  = 1'b0;

    launch = (state_q == IDLE) && tx_en && !fifo_empty;
    s_tick = (div_q == DW'(DVSR - 1));

    // The divider only runs during a frame and restarts from 0 at launch,
    // so every bit edge sits an exact multiple of DVSR after launch.
    if (state_q != IDLE) begin
      div_d = s_tick ? '0 : div_q + DW'(1);
    end

    case (state_q)
      IDLE: begin
        tx_d  = 1'b1;
        div_d = '0;
        if (launch) begin
          shift_d = fifo_r_data;
          tick_d  = '0;
          bit_d   = '0;
          tx_d    = 1'b0;
          state_d = START;
        end
      end
      START: begin
        if (s_tick) begin
          if (tick_q == TW'(15)) begin
            tick_d  = '0;
            tx_d    = shift_q[0];
            state_d = DATA;
          end else begin
            tick_d = tick_q + TW'(1);
          end
        end
      end
      DATA: begin
        if (s_tick) begin
          if (tick_q == TW'(15)) begin
            tick_d  = '0;
            shift_d = shift_q >> 1;
            if (bit_q == BW'(DBIT - 1)) begin
              tx_d    = 1'b1;
              state_d = STOP;
            end else begin
              bit_d = bit_q + BW'(1);
              // Next bit is the new LSB after the shift.
              tx_d  = shift_d[0];
            end
          end else begin
            tick_d = tick_q + TW'(1);
          end
        end
      end
      STOP: begin
        if (s_tick) begin
          if (tick_q == TW'(SB_TICK - 1)) begin
            tick_d  = '0;
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            tick_d = tick_q + TW'(1);
          end
        end
      end
      default: begin
        state_d = IDLE;
        tx_d    = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      div_q   <= '0;
      tick_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      tick_q  <= tick_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
      done_q  <= done_d;
    end
  end

  // Gated with reset so no pop is issued while reset is held; a word
  // popped before a mid-frame reset is simply lost.
  assign fifo_rd      = launch && reset;
  assign tx           = tx_q;
  assign tx_busy      = (state_q != IDLE);
  assign tx_done_tick = done_q;
  assign dbg_state    = state_q;

endmodule
